// File: rtl/fifo_dispatcher.sv
// fifo_dispatcher: steers one tagged input stream into NUM_REQS independent
// FIFOs, each drained by its own pop strobe. Protocol misuse (bad tag, pop
// while empty) is recorded in sticky flags and never disturbs FIFO state.
module fifo_dispatcher #(
    parameter int NUM_REQS = 2,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int IDW      = $clog2(NUM_REQS),
    parameter int CNTW     = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    input  logic [IDW-1:0]             in_dest,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       in_rdy,
    input  logic [NUM_REQS-1:0]        pop,
    output logic [NUM_REQS*WIDTH-1:0]  flat_data_out,
    output logic [NUM_REQS-1:0]        empty,
    output logic [NUM_REQS-1:0]        full,
    output logic [NUM_REQS*CNTW-1:0]   count,
    output logic                       drop_err,
    output logic [NUM_REQS-1:0]        pop_err
);
    localparam int PW = $clog2(DEPTH);

    logic dest_ok;
    logic full_sel;
    logic drop_err_q, drop_err_d;

    // Tags at or beyond NUM_REQS name no FIFO; they are swallowed, not stalled.
    assign dest_ok = (32'(in_dest) < NUM_REQS);

    // Select the full flag of the addressed FIFO; an invalid tag selects none.
    always_comb begin
        full_sel = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (in_dest == IDW'(i)) full_sel = full[i];
        end
    end

    assign in_rdy = ~dest_ok | ~full_sel;

    // Sticky record of any valid word carrying an out-of-range tag.
    always_comb begin
        drop_err_d = drop_err_q | (in_vld & ~dest_ok);
    end

    // Drop flag register; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) drop_err_q <= 1'b0;
        else     drop_err_q <= drop_err_d;
    end

    assign drop_err = drop_err_q;

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_fifo
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [CNTW-1:0]  cnt_q, cnt_d;
        logic             pop_err_q, pop_err_d;
        logic             is_full, is_empty;
        logic             do_push, do_pop;

        assign is_empty = (cnt_q == '0);
        assign is_full  = (cnt_q == CNTW'(DEPTH));

        // A full FIFO never accepts, even when it pops in the same cycle.
        assign do_push = in_vld & dest_ok & (in_dest == IDW'(g)) & ~is_full;
        assign do_pop  = pop[g] & ~is_empty;

        // Next-state for pointers, occupancy and the per-FIFO pop error.
        always_comb begin
            wr_ptr_d  = wr_ptr_q;
            rd_ptr_d  = rd_ptr_q;
            cnt_d     = cnt_q;
            pop_err_d = pop_err_q | (pop[g] & is_empty);
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        // Control state; reset wins over any push or pop in the same cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                cnt_q     <= '0;
                pop_err_q <= 1'b0;
            end else begin
                wr_ptr_q  <= wr_ptr_d;
                rd_ptr_q  <= rd_ptr_d;
                cnt_q     <= cnt_d;
                pop_err_q <= pop_err_d;
            end
        end

        // Storage is not reset; only entries between the pointers are visible.
        always_ff @(posedge clk) begin
            if (!rst && do_push) mem_q[wr_ptr_q] <= data_in;
        end

        assign empty[g]                        = is_empty;
        assign full[g]                         = is_full;
        assign count[g*CNTW +: CNTW]           = cnt_q;
        assign flat_data_out[g*WIDTH +: WIDTH] = is_empty ? '0 : mem_q[rd_ptr_q];
        assign pop_err[g]                      = pop_err_q;
    end

endmodule

// File: tb/tb_fifo_dispatcher.sv
// Bench for fifo_dispatcher: a constant table for fill/drain, a queue
// scoreboard for wrap/concurrency/full-with-pop, and hand sequences for the
// error flags and mid-operation reset. A 3-FIFO instance covers bad tags.
module tb_fifo_dispatcher;
    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Two-FIFO instance
    logic        rst, in_vld, in_rdy, drop_err;
    logic [0:0]  in_dest;
    logic [7:0]  data_in;
    logic [1:0]  pop, empty, full, pop_err;
    logic [15:0] flat;
    logic [5:0]  count;

    // Three-FIFO instance
    logic        rst3, vld3, rdy3, drop3;
    logic [1:0]  dest3;
    logic [7:0]  data3;
    logic [2:0]  pop3, empty3, full3, poperr3;
    logic [23:0] flat3;
    logic [8:0]  count3;

    fifo_dispatcher #(.NUM_REQS(2), .WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_dest(in_dest), .data_in(data_in),
        .in_rdy(in_rdy), .pop(pop), .flat_data_out(flat), .empty(empty), .full(full),
        .count(count), .drop_err(drop_err), .pop_err(pop_err));

    fifo_dispatcher #(.NUM_REQS(3), .WIDTH(8), .DEPTH(4)) dut3 (
        .clk(clk), .rst(rst3), .in_vld(vld3), .in_dest(dest3), .data_in(data3),
        .in_rdy(rdy3), .pop(pop3), .flat_data_out(flat3), .empty(empty3), .full(full3),
        .count(count3), .drop_err(drop3), .pop_err(poperr3));

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard queues for the two-FIFO instance
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    // One clock of stimulus with scoreboard-derived expectations.
    task automatic cycle(input logic v, input logic dst, input logic [7:0] d, input logic [1:0] p);
        logic exp_rdy;
        in_vld = v; in_dest = dst; data_in = d; pop = p;
        #1;
        exp_rdy = (dst == 1'b0) ? (q0.size() < D) : (q1.size() < D);
        chk("in_rdy", in_rdy, exp_rdy);
        if (p[0] && q0.size() > 0) chk("pop_head0", flat[7:0], q0.pop_front());
        if (p[1] && q1.size() > 0) chk("pop_head1", flat[15:8], q1.pop_front());
        if (v && exp_rdy) begin
            if (dst == 1'b0) q0.push_back(d);
            else             q1.push_back(d);
        end
        @(posedge clk); #1;
        chk("count0", count[2:0], q0.size());
        chk("count1", count[5:3], q1.size());
        chk("empty", empty, {q1.size() == 0, q0.size() == 0});
        chk("full", full, {q1.size() == D, q0.size() == D});
        chk("head0", flat[7:0], (q0.size() > 0) ? q0[0] : 8'h00);
        chk("head1", flat[15:8], (q1.size() > 0) ? q1[0] : 8'h00);
        in_vld = 1'b0; pop = 2'b00;
    endtask

    typedef struct {
        logic       vld;
        logic       dst;
        logic [7:0] data;
        logic [1:0] pop;
        logic       rdy;   // in_rdy before the edge
        logic [2:0] c0;    // after the edge
        logic [1:0] emp;
        logic [1:0] ful;
        logic [7:0] h0;
    } vec_t;

    vec_t tbl[9];

    initial begin
        // Fill then drain FIFO 0, expectations written out by hand.
        tbl[0] = '{1'b1, 1'b0, 8'h11, 2'b00, 1'b1, 3'd1, 2'b10, 2'b00, 8'h11};
        tbl[1] = '{1'b1, 1'b0, 8'h22, 2'b00, 1'b1, 3'd2, 2'b10, 2'b00, 8'h11};
        tbl[2] = '{1'b1, 1'b0, 8'h33, 2'b00, 1'b1, 3'd3, 2'b10, 2'b00, 8'h11};
        tbl[3] = '{1'b1, 1'b0, 8'h44, 2'b00, 1'b1, 3'd4, 2'b10, 2'b01, 8'h11};
        tbl[4] = '{1'b1, 1'b0, 8'h55, 2'b00, 1'b0, 3'd4, 2'b10, 2'b01, 8'h11};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 2'b01, 1'b0, 3'd3, 2'b10, 2'b00, 8'h22};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 2'b01, 1'b1, 3'd2, 2'b10, 2'b00, 8'h33};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 2'b01, 1'b1, 3'd1, 2'b10, 2'b00, 8'h44};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 2'b01, 1'b1, 3'd0, 2'b11, 2'b00, 8'h00};

        rst = 1'b1; in_vld = 1'b0; in_dest = 1'b0; data_in = 8'h00; pop = 2'b00;
        rst3 = 1'b1; vld3 = 1'b0; dest3 = 2'd0; data3 = 8'h00; pop3 = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst3 = 1'b0;

        // Reset state
        chk("rst_empty", empty, 2'b11);
        chk("rst_full", full, 2'b00);
        chk("rst_count", count, 6'd0);
        chk("rst_data", flat, 16'h0000);
        chk("rst_drop", drop_err, 1'b0);
        chk("rst_poperr", pop_err, 2'b00);
        chk("rst_rdy_d0", in_rdy, 1'b1);
        in_dest = 1'b1; #1;
        chk("rst_rdy_d1", in_rdy, 1'b1);
        chk("rst3_empty", empty3, 3'b111);

        // Table: fill and drain
        for (int k = 0; k < 9; k++) begin
            in_vld = tbl[k].vld; in_dest = tbl[k].dst; data_in = tbl[k].data; pop = tbl[k].pop;
            #1;
            chk($sformatf("tbl%0d_rdy", k), in_rdy, tbl[k].rdy);
            if (tbl[k].rdy == 1'b0 && tbl[k].vld) begin
                in_dest = 1'b1; #1;
                chk($sformatf("tbl%0d_rdy_d1", k), in_rdy, 1'b1);
                in_dest = tbl[k].dst; #1;
            end
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_count0", k), count[2:0], tbl[k].c0);
            chk($sformatf("tbl%0d_empty", k), empty, tbl[k].emp);
            chk($sformatf("tbl%0d_full", k), full, tbl[k].ful);
            chk($sformatf("tbl%0d_head0", k), flat[7:0], tbl[k].h0);
            in_vld = 1'b0; pop = 2'b00;
        end
        chk("drain_poperr0", pop_err[0], 1'b0);

        // Wrap and concurrency on FIFO 1
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b1, 8'hA0 + 8'(k), (k > 0) ? 2'b10 : 2'b00);
            chk("wrap_count1", count[5:3], 3'd1);
        end
        cycle(1'b0, 1'b0, 8'h00, 2'b10);

        // Full FIFO 0 with simultaneous pop: push refused that cycle
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 8'hC0 + 8'(k), 2'b00);
        cycle(1'b1, 1'b0, 8'h55, 2'b01);
        chk("fullpop_count0", count[2:0], 3'd3);
        cycle(1'b1, 1'b0, 8'h55, 2'b00);
        chk("refill_count0", count[2:0], 3'd4);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 8'h00, 2'b01);

        // Pop of empty FIFO 1
        cycle(1'b0, 1'b0, 8'h00, 2'b10);
        chk("poperr", pop_err, 2'b10);
        chk("poperr_count1", count[5:3], 3'd0);

        // Out-of-range tag on the three-FIFO instance
        vld3 = 1'b1; dest3 = 2'd3; data3 = 8'hEE;
        #1;
        chk("drop_rdy", rdy3, 1'b1);
        @(posedge clk); #1;
        chk("drop_err", drop3, 1'b1);
        chk("drop_empty", empty3, 3'b111);
        chk("drop_count", count3, 9'd0);
        dest3 = 2'd2; data3 = 8'h5A;
        @(posedge clk); #1;
        vld3 = 1'b0;
        chk("d3_count2", count3[8:6], 3'd1);
        chk("d3_head2", flat3[23:16], 8'h5A);
        chk("d3_empty", empty3, 3'b011);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_hold", drop3, 1'b1);
        chk("poperr_hold", pop_err, 2'b10);

        // Mid-operation reset with push and pop in the same cycle
        cycle(1'b1, 1'b0, 8'h61, 2'b00);
        cycle(1'b1, 1'b0, 8'h62, 2'b00);
        chk("pre_rst_count0", count[2:0], 3'd2);
        rst = 1'b1; rst3 = 1'b1;
        in_vld = 1'b1; in_dest = 1'b0; data_in = 8'h77; pop = 2'b01;
        @(posedge clk); #1;
        rst = 1'b0; rst3 = 1'b0; in_vld = 1'b0; pop = 2'b00;
        q0.delete(); q1.delete();
        chk("mrst_count0", count[2:0], 3'd0);
        chk("mrst_empty", empty, 2'b11);
        chk("mrst_data", flat, 16'h0000);
        chk("mrst_poperr", pop_err, 2'b00);
        chk("mrst_drop3", drop3, 1'b0);
        chk("mrst_empty3", empty3, 3'b111);
        cycle(1'b0, 1'b0, 8'h00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fifo_dispatcher.md
# fifo_dispatcher

Single-input, multi-output steering buffer: the write-side counterpart of the arbitrated FIFO bank. One producer presents a tagged data stream, and the block routes each accepted word into one of NUM_REQS per-destination FIFOs. Each consumer drains its FIFO independently with a pop strobe. It feeds per-channel consumers, or SimpleScoreboard instances, in formal and simulation harnesses, and reports protocol violations as sticky flags instead of corrupting state.

## Interface
- NUM_REQS, 2, number of destination FIFOs (≥2)
- WIDTH, 8, data word width
- DEPTH, 4, entries per FIFO; power of two, ≥2
- IDW, $clog2(NUM_REQS), destination tag width
- CNTW, $clog2(DEPTH+1), occupancy counter width

Ports:
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- in_vld  in  1  producer has a word
- in_dest  in  IDW  destination FIFO index
- data_in  in  WIDTH  producer word
- in_rdy  out  1  word is accepted this cycle if in_vld is also high
- pop  in  NUM_REQS  per-FIFO consume strobe
- flat_data_out  out  NUM_REQS*WIDTH  head word of FIFO i at bits [(i+1)*WIDTH-1 : i*WIDTH]
- empty  out  NUM_REQS  FIFO i holds 0 words
- full  out  NUM_REQS  FIFO i holds DEPTH words
- count  out  NUM_REQS*CNTW  per-FIFO occupancy, packed the same way as flat_data_out
- drop_err  out  1  sticky: a valid word had in_dest ≥ NUM_REQS
- pop_err  out  NUM_REQS  sticky per FIFO: pop seen while empty

## Operation
- Each FIFO has a circular memory of DEPTH words, rd/wr pointers of width $clog2(DEPTH) that wrap naturally, and an occupancy counter.
- in_rdy is combinational: in_rdy = (in_dest ≥ NUM_REQS) | !full[in_dest].
  - An out-of-range tag is therefore always "accepted".
- Accept = in_vld & in_rdy.
  - Legal tag: write data_in at wr_ptr[in_dest], increment wr_ptr and count.
  - Illegal tag: the word is discarded and drop_err is set.
- Pop on a non-empty FIFO increments rd_ptr and decrements count.
- Pop on an empty FIFO is ignored and sets pop_err[i]. Pointers and count are unchanged.
- Push and pop on the same non-full, non-empty FIFO in the same cycle: both occur, and count is unchanged.
- Push and pop on an empty FIFO in the same cycle: the pop is illegal (pop_err set) and the push proceeds. There is no bypass.
- Push to a full FIFO is never accepted, even if the same FIFO pops that cycle. in_rdy stays low for that cycle.
- Output derivation:
  - empty[i] = (count_i == 0)
  - full[i] = (count_i == DEPTH)
  - data head is mem_i[rd_ptr_i] when non-empty, and all-zeros when empty.
- Sticky flags clear only on rst.
- FIFOs are fully independent. Pops on any subset of FIFOs proceed concurrently with one push.

## Timing
- Reset: all pointers and counts become 0.
  - empty = all ones; full = 0; count = 0; flat_data_out = 0; drop_err = 0; pop_err = 0.
  - in_rdy = 1 for any in_dest.
- Reset asserted mid-operation discards all contents on that edge. Any push or pop sampled in that cycle is ignored.
- Write latency is 1 cycle. A word accepted at edge N drives the head of an empty FIFO, deasserts empty, and updates count after edge N.
- Full asserts after the edge of the DEPTH-th net push. in_rdy for that destination drops combinationally in the same cycle.
- Pop at edge N: the next head word (or zeros) is visible after edge N. full deasserts after edge N.
- Memory contents are not reset; only valid entries are ever observable.

## Test plan
- Fill: after rst, push 0x11, 0x22, 0x33, 0x44 to dest 0 on consecutive cycles.
  - Required: full[0]=1 and count0=4 after the 4th edge; in_rdy=0 with in_dest=0; in_rdy=1 with in_dest=1; empty[1] stays 1.
- Drain order: pop dest 0 four times.
  - Required: heads 0x11, 0x22, 0x33, 0x44 in that order; then empty[0]=1, data slice 0 = 0x00, and pop_err[0] remains 0.
- Wrap and concurrency, DEPTH=4:
  - Push 6 words to dest 1 while popping each cycle from the second cycle on.
  - Required: count1 stays at 1 and FIFO order is preserved across the pointer wrap.
- Full plus simultaneous pop:
  - With FIFO 0 full, assert in_vld (dest 0, 0x55) and pop[0] together.
  - Required: the word is not accepted, count0 = 3.
  - Next cycle 0x55 is accepted and count0 returns to 4.
- Errors:
  - Pop the empty FIFO 1: pop_err[1]=1, with no count change.
  - With NUM_REQS=3, send in_dest=3: drop_err=1, in_rdy=1, and no FIFO changes.
  - Both flags hold until rst, then clear.
- Mid-operation reset: with FIFO 0 at count 2, assert rst together with push and pop.
  - Required after the edge: count0=0, empty=all ones, and nothing written.
